// File: rtl/dff_shift_pipe.sv
// ---------------------------------------------------------------------------
// dff_shift_pipe
//   Parametrised register chain of DEPTH stages, each WIDTH bits wide, on a
//   single clock. Supports synchronous reset, parallel load, enabled shifting
//   in either direction, and fill-level tracking. Typical uses are a
//   programmable delay line and a serial<->parallel converter.
//
//   Build option:
//     SHREG_PAR_OUT_EN - when defined, adds port par_out, which is a direct
//                        view of every stage register.
//
// Parameters
//   WIDTH     bits per stage (>= 1)
//   DEPTH     number of stages (>= 1)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   en        shift enable
//   load      parallel load strobe; takes priority over en
//   dir       0: shift toward stage DEPTH-1; 1: shift toward stage 0
//   d_in      serial data entering the chain
//   par_in    parallel load data; stage k = par_in[k*WIDTH +: WIDTH]
//   q_out     serial output: stage DEPTH-1 when dir=0, stage 0 when dir=1
//   fill_cnt  number of valid stages, 0..DEPTH; saturates at DEPTH
//   full      fill_cnt == DEPTH
//   par_out   (SHREG_PAR_OUT_EN only) stage k at par_out[k*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module dff_shift_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           load,
   input  logic                           dir,
   input  logic [WIDTH-1:0]               d_in,
   input  logic [WIDTH*DEPTH-1:0]         par_in,
   output logic [WIDTH-1:0]               q_out,
   output logic [$clog2(DEPTH+1)-1:0]     fill_cnt,
   output logic                           full
`ifdef SHREG_PAR_OUT_EN
   ,
   output logic [WIDTH*DEPTH-1:0]         par_out
`endif
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   // Stage k lives at index k, so the packed layout matches par_in/par_out.
   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;
   logic [CW-1:0]               cnt_q;
   logic [CW-1:0]               cnt_d;

   // Chain extended by the serial input on one end. Slicing these avoids
   // out-of-range stage indices at the chain ends, including when DEPTH=1.
   logic [DEPTH:0][WIDTH-1:0]   ext_up;
   logic [DEPTH:0][WIDTH-1:0]   ext_dn;

   assign ext_up = {stage_q, d_in};   // ext_up[0] = d_in, ext_up[k+1] = stage_q[k]
   assign ext_dn = {d_in, stage_q};   // ext_dn[k] = stage_q[k], ext_dn[DEPTH] = d_in

   // Next-state: load beats shift beats hold; reset is applied in the register.
   always_comb begin
      stage_d = stage_q;
      cnt_d   = cnt_q;
      if (load) begin
         stage_d = par_in;
         cnt_d   = CW'(DEPTH);
      end else if (en) begin
         if (dir) begin
            stage_d = ext_dn[DEPTH:1];
         end else begin
            stage_d = ext_up[DEPTH-1:0];
         end
         // Saturate so that full persists while the oldest entry drops off.
         if (cnt_q != CW'(DEPTH)) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
      end
   end

   // Serial output follows the current direction, taken from the end data
   // leaves the chain in that direction.
   assign q_out    = dir ? stage_q[0] : stage_q[DEPTH-1];
   assign fill_cnt = cnt_q;
   assign full     = (cnt_q == CW'(DEPTH));

`ifdef SHREG_PAR_OUT_EN
   assign par_out  = stage_q;
`endif

endmodule

// File: tb/tb_dff_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_dff_shift_pipe
//   Directed self-checking bench. The main instance uses WIDTH=8 and DEPTH=4.
//   A second instance uses WIDTH=1 and DEPTH=1 for the single-register case.
// ---------------------------------------------------------------------------
module tb_dff_shift_pipe;

   logic        clk;
   logic        rst;
   logic        en;
   logic        load;
   logic        dir;
   logic [7:0]  d_in;
   logic [31:0] par_in;
   logic [7:0]  q_out;
   logic [2:0]  fill_cnt;
   logic        full;
`ifdef SHREG_PAR_OUT_EN
   logic [31:0] par_out;
`endif

   logic        rst1;
   logic        en1;
   logic        load1;
   logic        dir1;
   logic        d_in1;
   logic        par_in1;
   logic        q_out1;
   logic        fill_cnt1;
   logic        full1;
`ifdef SHREG_PAR_OUT_EN
   logic        par_out1;
`endif

   int assert_cnt = 0;
   int fail_cnt   = 0;

   dff_shift_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .dir      (dir),
      .d_in     (d_in),
      .par_in   (par_in),
      .q_out    (q_out),
      .fill_cnt (fill_cnt),
      .full     (full)
`ifdef SHREG_PAR_OUT_EN
      ,
      .par_out  (par_out)
`endif
   );

   dff_shift_pipe #(.WIDTH(1), .DEPTH(1)) u_dut1 (
      .clk      (clk),
      .rst      (rst1),
      .en       (en1),
      .load     (load1),
      .dir      (dir1),
      .d_in     (d_in1),
      .par_in   (par_in1),
      .q_out    (q_out1),
      .fill_cnt (fill_cnt1),
      .full     (full1)
`ifdef SHREG_PAR_OUT_EN
      ,
      .par_out  (par_out1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic shift_byte(input logic [7:0] v);
      en = 1'b1; d_in = v;
      tick();
      en = 1'b0;
   endtask

   task automatic test_reset();
      load = 1'b1; par_in = $urandom | 32'h0100_0001; en = 1'b0; rst = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; d_in = 8'h5A;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0; dir = 1'b0; #1;
      assert_cnt++; if (q_out !== 8'h00) begin fail_cnt++; $display("FAIL reset_q_up got %h exp 00", q_out); end
      assert_cnt++; if (fill_cnt !== 3'd0) begin fail_cnt++; $display("FAIL reset_fill got %0d exp 0", fill_cnt); end
      assert_cnt++; if (full !== 1'b0) begin fail_cnt++; $display("FAIL reset_full got %b exp 0", full); end
      dir = 1'b1; #1;
      assert_cnt++; if (q_out !== 8'h00) begin fail_cnt++; $display("FAIL reset_q_down got %h exp 00", q_out); end
`ifdef SHREG_PAR_OUT_EN
      assert_cnt++; if (par_out !== 32'h0) begin fail_cnt++; $display("FAIL reset_par_out got %h exp 0", par_out); end
`endif
      dir = 1'b0;
   endtask

   task automatic test_shift_up();
      do_reset();
      dir = 1'b0;
      shift_byte(8'h11);
      assert_cnt++; if (fill_cnt !== 3'd1) begin fail_cnt++; $display("FAIL up_fill1 got %0d exp 1", fill_cnt); end
      shift_byte(8'h22);
      shift_byte(8'h33);
      assert_cnt++; if (q_out !== 8'h00) begin fail_cnt++; $display("FAIL up_q3 got %h exp 00", q_out); end
      shift_byte(8'h44);
      assert_cnt++; if (q_out !== 8'h11) begin fail_cnt++; $display("FAIL up_q4 got %h exp 11", q_out); end
      assert_cnt++; if (fill_cnt !== 3'd4) begin fail_cnt++; $display("FAIL up_fill4 got %0d exp 4", fill_cnt); end
      assert_cnt++; if (full !== 1'b1) begin fail_cnt++; $display("FAIL up_full4 got %b exp 1", full); end
`ifdef SHREG_PAR_OUT_EN
      assert_cnt++; if (par_out !== 32'h1122_3344) begin fail_cnt++; $display("FAIL up_par_out got %h exp 11223344", par_out); end
`endif
      shift_byte(8'h55);
      assert_cnt++; if (q_out !== 8'h22) begin fail_cnt++; $display("FAIL up_q5 got %h exp 22", q_out); end
      assert_cnt++; if (fill_cnt !== 3'd4) begin fail_cnt++; $display("FAIL up_fill_sat got %0d exp 4", fill_cnt); end
      assert_cnt++; if (full !== 1'b1) begin fail_cnt++; $display("FAIL up_full_sat got %b exp 1", full); end
   endtask

   task automatic test_load_down();
      do_reset();
      load = 1'b1; en = 1'b1; dir = 1'b0; d_in = 8'hFF; par_in = 32'h4433_2211;
      tick();
      load = 1'b0; en = 1'b0; #1;
      assert_cnt++; if (fill_cnt !== 3'd4) begin fail_cnt++; $display("FAIL load_fill got %0d exp 4", fill_cnt); end
      assert_cnt++; if (q_out !== 8'h44) begin fail_cnt++; $display("FAIL load_stage3 got %h exp 44", q_out); end
      dir = 1'b1; #1;
      assert_cnt++; if (q_out !== 8'h11) begin fail_cnt++; $display("FAIL load_stage0 got %h exp 11", q_out); end
`ifdef SHREG_PAR_OUT_EN
      assert_cnt++; if (par_out !== 32'h4433_2211) begin fail_cnt++; $display("FAIL load_par_out got %h exp 44332211", par_out); end
`endif
      shift_byte(8'hAA);
      assert_cnt++; if (q_out !== 8'h22) begin fail_cnt++; $display("FAIL down_q got %h exp 22", q_out); end
      dir = 1'b0; #1;
      assert_cnt++; if (q_out !== 8'hAA) begin fail_cnt++; $display("FAIL down_stage3 got %h exp AA", q_out); end
      assert_cnt++; if (fill_cnt !== 3'd4) begin fail_cnt++; $display("FAIL down_fill got %0d exp 4", fill_cnt); end
`ifdef SHREG_PAR_OUT_EN
      assert_cnt++; if (par_out !== 32'hAA44_3322) begin fail_cnt++; $display("FAIL down_par_out got %h exp AA443322", par_out); end
`endif
   endtask

   task automatic test_hold();
      do_reset();
      dir = 1'b0;
      shift_byte(8'h11);
      shift_byte(8'h22);
      for (int i = 0; i < 3; i++) begin
         d_in = 8'hEE;
         tick();
         assert_cnt++; if (fill_cnt !== 3'd2) begin fail_cnt++; $display("FAIL hold_fill[%0d] got %0d exp 2", i, fill_cnt); end
         assert_cnt++; if (q_out !== 8'h00) begin fail_cnt++; $display("FAIL hold_q[%0d] got %h exp 00", i, q_out); end
      end
      shift_byte(8'h33);
      shift_byte(8'h44);
      assert_cnt++; if (q_out !== 8'h11) begin fail_cnt++; $display("FAIL hold_q_after got %h exp 11", q_out); end
      assert_cnt++; if (fill_cnt !== 3'd4) begin fail_cnt++; $display("FAIL hold_fill_after got %0d exp 4", fill_cnt); end
   endtask

   task automatic test_dir_change();
      do_reset();
      dir = 1'b0;
      shift_byte(8'h11);
      shift_byte(8'h22);
      shift_byte(8'h33);
      dir = 1'b1;
      shift_byte(8'h77);
      assert_cnt++; if (q_out !== 8'h22) begin fail_cnt++; $display("FAIL dirchg_stage0 got %h exp 22", q_out); end
      assert_cnt++; if (fill_cnt !== 3'd4) begin fail_cnt++; $display("FAIL dirchg_fill got %0d exp 4", fill_cnt); end
      dir = 1'b0; #1;
      assert_cnt++; if (q_out !== 8'h77) begin fail_cnt++; $display("FAIL dirchg_stage3 got %h exp 77", q_out); end
   endtask

   task automatic test_priority();
      do_reset();
      load = 1'b1; par_in = 32'hDEAD_BEEF;
      tick();
      rst = 1'b1; load = 1'b1; en = 1'b1; par_in = 32'h1234_5678;
      tick();
      rst = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; #1;
      assert_cnt++; if (fill_cnt !== 3'd0) begin fail_cnt++; $display("FAIL prio_fill got %0d exp 0", fill_cnt); end
      assert_cnt++; if (q_out !== 8'h00) begin fail_cnt++; $display("FAIL prio_q_up got %h exp 00", q_out); end
      dir = 1'b1; #1;
      assert_cnt++; if (q_out !== 8'h00) begin fail_cnt++; $display("FAIL prio_q_down got %h exp 00", q_out); end
      dir = 1'b0;
      shift_byte(8'h11);
      shift_byte(8'h22);
      rst = 1'b1; en = 1'b1; d_in = 8'h33;
      tick();
      rst = 1'b0; en = 1'b0; #1;
      assert_cnt++; if (fill_cnt !== 3'd0) begin fail_cnt++; $display("FAIL midrst_fill got %0d exp 0", fill_cnt); end
      assert_cnt++; if (full !== 1'b0) begin fail_cnt++; $display("FAIL midrst_full got %b exp 0", full); end
      dir = 1'b1; #1;
      assert_cnt++; if (q_out !== 8'h00) begin fail_cnt++; $display("FAIL midrst_q got %h exp 00", q_out); end
      dir = 1'b0;
   endtask

   task automatic test_depth1();
      rst1 = 1'b1; en1 = 1'b0; load1 = 1'b0; dir1 = 1'b0; d_in1 = 1'b0; par_in1 = 1'b0;
      tick();
      rst1 = 1'b0; #1;
      assert_cnt++; if (full1 !== 1'b0) begin fail_cnt++; $display("FAIL d1_reset_full got %b exp 0", full1); end
      en1 = 1'b1; d_in1 = 1'b1;
      tick();
      en1 = 1'b0; #1;
      assert_cnt++; if (q_out1 !== 1'b1) begin fail_cnt++; $display("FAIL d1_q got %b exp 1", q_out1); end
      assert_cnt++; if (full1 !== 1'b1) begin fail_cnt++; $display("FAIL d1_full got %b exp 1", full1); end
      assert_cnt++; if (fill_cnt1 !== 1'b1) begin fail_cnt++; $display("FAIL d1_fill got %b exp 1", fill_cnt1); end
      dir1 = 1'b1; #1;
      assert_cnt++; if (q_out1 !== 1'b1) begin fail_cnt++; $display("FAIL d1_q_dir got %b exp 1", q_out1); end
      en1 = 1'b1; d_in1 = 1'b0;
      tick();
      en1 = 1'b0; #1;
      assert_cnt++; if (q_out1 !== 1'b0) begin fail_cnt++; $display("FAIL d1_q_shift0 got %b exp 0", q_out1); end
      assert_cnt++; if (full1 !== 1'b1) begin fail_cnt++; $display("FAIL d1_full_stay got %b exp 1", full1); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b0; d_in = '0; par_in = '0;
      rst1 = 1'b1; en1 = 1'b0; load1 = 1'b0; dir1 = 1'b0; d_in1 = 1'b0; par_in1 = 1'b0;
      tick();
      rst = 1'b0; rst1 = 1'b0;
      test_reset();
      test_shift_up();
      test_load_down();
      test_hold();
      test_dir_change();
      test_priority();
      test_depth1();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
